// File: rtl/uart_rx_v2.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_v2
//  Description : Oversampling UART receiver. The line is synchronised, each
//                bit is decided by a 3-sample majority vote at the end of its
//                bit time, and the word plus parity/frame/break flags are
//                published with a one-clock o_valid pulse. After a framing
//                error the receiver waits for the line to go high again so a
//                held-low line yields a single break frame.
//                Optional feature macro: UART_RX_PARITY_EN (adds a parity bit
//                between data and stop bits).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_v2 #(
    parameter int NB_DATA      = 8,
    parameter int N_OVERSAMPLE = 16,
    parameter int NB_STOP_BITS = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_valid,
    output logic               o_parity_err,
    output logic               o_frame_err,
    output logic               o_break,
    output logic               o_busy
);

    localparam int                CNT_W       = $clog2(N_OVERSAMPLE);
    localparam logic [CNT_W-1:0] c_cnt_half  = CNT_W'(N_OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] c_cnt_last  = CNT_W'(N_OVERSAMPLE - 1);
    localparam logic [3:0]       c_data_last = 4'(NB_DATA - 1);
    localparam logic [3:0]       c_stop_last = 4'(NB_STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY    = 3'd3,
`endif
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    logic               rx_meta_q, rx_sync_q;
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         bit_q, bit_d;
    logic [1:0]         samp_q, samp_d;
    logic [NB_DATA-1:0] shift_q, shift_d;
    logic               ferr_q, ferr_d;
    logic               par_q, par_d;
    logic [NB_DATA-1:0] data_q, data_d;
    logic               valid_q, valid_d;
    logic               perr_q, perr_d;
    logic               fe_q, fe_d;
    logic               brk_q, brk_d;
    logic               w_maj;
    logic               w_fe;
    logic               w_perr;

    // Two-flop synchroniser on the asynchronous line; idles high out of reset.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Majority of the samples taken at counts N-3, N-2 (history) and N-1 (now).
    assign w_maj = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx_sync_q) | (samp_q[0] & rx_sync_q);

    // Frame error includes the stop bit being decided in this cycle.
    assign w_fe = ferr_q | ~w_maj;

`ifdef UART_RX_PARITY_EN
    localparam logic c_par_odd = (PARITY_ODD != 0);
    assign w_perr = (^shift_q) ^ par_q ^ c_par_odd;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = (PARITY_ODD != 0);
    assign w_perr = 1'b0;
`endif

    // Next-state and datapath logic; everything advances only on tick clocks.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        samp_d  = samp_q;
        shift_d = shift_q;
        ferr_d  = ferr_q;
        par_d   = par_q;
        data_d  = data_q;
        perr_d  = perr_q;
        fe_d    = fe_q;
        brk_d   = brk_q;
        valid_d = 1'b0;
        if (i_tick) begin
            samp_d = {samp_q[0], rx_sync_q};
            case (state_q)
                S_IDLE: begin
                    if (!rx_sync_q) begin
                        state_d = S_START;
                        cnt_d   = '0;
                    end
                end
                S_START: begin
                    if (cnt_q == c_cnt_half) begin
                        cnt_d   = '0;
                        bit_d   = '0;
                        state_d = rx_sync_q ? S_IDLE : S_DATA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == c_cnt_last) begin
                        cnt_d   = '0;
                        shift_d = {w_maj, shift_q[NB_DATA-1:1]};
                        if (bit_q == c_data_last) begin
                            bit_d  = '0;
                            ferr_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            par_d   = 1'b0;
                            state_d = S_STOP;
`endif
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt_q == c_cnt_last) begin
                        cnt_d   = '0;
                        par_d   = w_maj;
                        state_d = S_STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (cnt_q == c_cnt_last) begin
                        cnt_d = '0;
                        if (bit_q == c_stop_last) begin
                            // Publish the frame; the pulse appears after this edge.
                            data_d  = shift_q;
                            fe_d    = w_fe;
                            perr_d  = w_perr;
                            brk_d   = w_fe & (shift_q == '0) & ~par_q;
                            valid_d = 1'b1;
                            bit_d   = '0;
                            state_d = w_fe ? S_WAIT_HIGH : S_IDLE;
                        end else begin
                            ferr_d = w_fe;
                            bit_d  = bit_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    if (rx_sync_q) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            endcase
        end
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            samp_q  <= '0;
            shift_q <= '0;
            ferr_q  <= 1'b0;
            par_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            fe_q    <= 1'b0;
            brk_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            samp_q  <= samp_d;
            shift_q <= shift_d;
            ferr_q  <= ferr_d;
            par_q   <= par_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            fe_q    <= fe_d;
            brk_q   <= brk_d;
        end
    end

    assign o_data       = data_q;
    assign o_valid      = valid_q;
    assign o_parity_err = perr_q;
    assign o_frame_err  = fe_q;
    assign o_break      = brk_q;
    assign o_busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_v2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_v2
//  Description : Self-checking bench for uart_rx_v2. Frames are driven on the
//                line bit by bit; expected word and flags are derived from the
//                transmitted bits and compared with every o_valid capture.
//                Honours UART_RX_PARITY_EN to match the DUT build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_v2;

    localparam int c_nb_data = 8;
    localparam int c_n       = 16;
    localparam int c_nstop   = 1;
    localparam int c_podd    = 0;
    localparam int c_tdiv    = 3;
`ifdef UART_RX_PARITY_EN
    localparam bit c_par_en  = 1'b1;
`else
    localparam bit c_par_en  = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       br;
    } obs_t;

    logic       clk;
    logic       i_rst_n;
    logic       i_tick;
    logic       i_rx;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_parity_err;
    logic       o_frame_err;
    logic       o_break;
    logic       o_busy;

    obs_t obs_q[$];
    int   n_checks = 0;
    int   n_errs   = 0;

    uart_rx_v2 #(
        .NB_DATA      (c_nb_data),
        .N_OVERSAMPLE (c_n),
        .NB_STOP_BITS (c_nstop),
        .PARITY_ODD   (c_podd)
    ) dut (
        .clk          (clk),
        .i_rst_n      (i_rst_n),
        .i_tick       (i_tick),
        .i_rx         (i_rx),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_parity_err (o_parity_err),
        .o_frame_err  (o_frame_err),
        .o_break      (o_break),
        .o_busy       (o_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-clock tick every c_tdiv clocks.
    initial begin
        i_tick = 1'b0;
        forever begin
            repeat (c_tdiv - 1) @(negedge clk);
            i_tick = 1'b1;
            @(negedge clk);
            i_tick = 1'b0;
        end
    end

    // Capture every published frame.
    always @(negedge clk) begin
        if (i_rst_n && o_valid)
            obs_q.push_back({o_data, o_parity_err, o_frame_err, o_break});
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n * c_tdiv) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input int n);
        i_rx = b;
        wait_ticks(n);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop_v);
        send_bit(1'b0, c_n);
        for (int i = 0; i < 8; i++) send_bit(d[i], c_n);
`ifdef UART_RX_PARITY_EN
        send_bit(p, c_n);
`endif
        for (int s = 0; s < c_nstop; s++) send_bit(stop_v, c_n);
    endtask

    // Reference: the frame the line carried determines the published result.
    task automatic expect_frame(input string tag, input logic [7:0] d, input logic p, input logic stop_v);
        obs_t o;
        logic fe, pe, br;
        fe = (stop_v == 1'b0);
        pe = c_par_en ? ((($countones(d) + int'(p)) % 2) != c_podd) : 1'b0;
        br = fe && (d == 8'h00) && (!c_par_en || p == 1'b0);
        check_eq({tag, ".count"}, obs_q.size(), 1);
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            check_eq({tag, ".data"}, o.d, d);
            check_eq({tag, ".frame_err"}, o.fe, fe);
            check_eq({tag, ".parity_err"}, o.pe, pe);
            check_eq({tag, ".break"}, o.br, br);
        end
        obs_q.delete();
    endtask

    function automatic logic good_par(input logic [7:0] d);
        return ((^d) ^ (c_podd != 0));
    endfunction

    initial begin
        logic [7:0] d;
        logic       p;
        logic       sv;
        int         gap;

        i_rst_n = 1'b0;
        i_rx    = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check_eq("rst.data",  o_data, 0);
        check_eq("rst.valid", o_valid, 0);
        check_eq("rst.perr",  o_parity_err, 0);
        check_eq("rst.ferr",  o_frame_err, 0);
        check_eq("rst.brk",   o_break, 0);
        check_eq("rst.busy",  o_busy, 0);
        @(negedge clk);
        i_rst_n = 1'b1;
        wait_ticks(c_n);

        // Clean frame
        send_frame(8'h12, good_par(8'h12), 1'b1);
        expect_frame("f12", 8'h12, good_par(8'h12), 1'b1);
        send_bit(1'b1, c_n);
        check_eq("f12.busy_after", o_busy, 0);

        // False start: short low pulse
        send_bit(1'b0, 4);
        send_bit(1'b1, 12);
        check_eq("false_start.valid", obs_q.size(), 0);
        check_eq("false_start.busy", o_busy, 0);
        obs_q.delete();

        // Stop bit forced low, then clean frame
        send_frame(8'h34, good_par(8'h34), 1'b0);
        expect_frame("f34_ferr", 8'h34, good_par(8'h34), 1'b0);
        send_bit(1'b1, c_n);
        send_frame(8'h05, good_par(8'h05), 1'b1);
        expect_frame("f05", 8'h05, good_par(8'h05), 1'b1);
        send_bit(1'b1, c_n);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h05, 1'b0, 1'b1);
        expect_frame("par_ok", 8'h05, 1'b0, 1'b1);
        send_bit(1'b1, c_n);
        send_frame(8'h05, 1'b1, 1'b1);
        expect_frame("par_bad", 8'h05, 1'b1, 1'b1);
        send_bit(1'b1, c_n);
`endif

        // Line held low for 20 bit times: one break frame only
        send_bit(1'b0, 20 * c_n);
        send_bit(1'b1, c_n);
        expect_frame("break", 8'h00, 1'b0, 1'b0);
        send_frame(8'h03, good_par(8'h03), 1'b1);
        expect_frame("f03", 8'h03, good_par(8'h03), 1'b1);
        send_bit(1'b1, c_n);

        // 0xFF with a one-tick low glitch at the centre of data bit 2
        send_bit(1'b0, c_n);
        send_bit(1'b1, c_n);
        send_bit(1'b1, c_n);
        send_bit(1'b1, c_n / 2 - 1);
        send_bit(1'b0, 1);
        send_bit(1'b1, c_n / 2);
        for (int i = 3; i < 8; i++) send_bit(1'b1, c_n);
`ifdef UART_RX_PARITY_EN
        send_bit(good_par(8'hFF), c_n);
`endif
        send_bit(1'b1, c_n);
        expect_frame("glitch", 8'hFF, good_par(8'hFF), 1'b1);
        send_bit(1'b1, c_n);

        // Second frame (0xF8) cut by reset during bit 3 (line high there)
        send_bit(1'b0, c_n);
        for (int i = 0; i < 3; i++) send_bit(1'b0, c_n);
        send_bit(1'b1, 4);
        i_rst_n = 1'b0;
        #1;
        check_eq("midrst.busy", o_busy, 0);
        check_eq("midrst.data", o_data, 0);
        wait_ticks(2);
        i_rst_n = 1'b1;
        send_bit(1'b1, c_n - 6);
        for (int i = 4; i < 8; i++) send_bit(1'b1, c_n);
        send_bit(1'b1, 2 * c_n);
        check_eq("midrst.no_valid", obs_q.size(), 0);
        check_eq("midrst.busy_after", o_busy, 0);
        obs_q.delete();
        send_frame(8'h20, good_par(8'h20), 1'b1);
        expect_frame("f20", 8'h20, good_par(8'h20), 1'b1);
        send_bit(1'b1, c_n);

        // Randomised frames, occasional bad stop/parity, varied gaps
        for (int k = 0; k < 16; k++) begin
            d  = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) d = 8'h00;
            sv = ($urandom_range(0, 4) != 0);
            p  = good_par(d) ^ ($urandom_range(0, 4) == 0);
            send_frame(d, p, sv);
            expect_frame($sformatf("rnd%0d", k), d, p, sv);
            gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 40);
            if (!sv) gap += c_n;
            if (gap > 0) send_bit(1'b1, gap);
        end
        send_bit(1'b1, c_n);
        check_eq("end.busy", o_busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
